// File: rtl/score_display_pkg.sv
// score_display_pkg: shared types and constants for the score display slice.
// Conversion FSM states, saturation limit, iteration count and the active-low
// seven-segment patterns ({g,f,e,d,c,b,a}) used by score_display.
package score_display_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLoad
    } conv_state_t;

    localparam int unsigned SAT_MAX    = 9999;
    localparam int unsigned CONV_ITERS = 14;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Non-decimal nibbles blank the digit rather than showing garbage.
    function automatic logic [6:0] seg_decode(logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 14-bit binary to 4 BCD digits.
// start is accepted only in StIdle; bcd holds the last finished result and done
// pulses for one cycle when it is updated.
module bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    conv_state_t state_q;
    logic [13:0] bin_q;
    logic [15:0] scratch_q;
    logic [15:0] scratch_adj;
    logic [3:0]  iter_q;
    logic [15:0] bcd_q;
    logic        done_q;

    // Add-3 correction on every nibble that would overflow past 9 when doubled.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_adj[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_adj[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: capture, 14 correct-and-shift steps, publish.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= StIdle;
            bin_q     <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        bin_q     <= bin;
                        scratch_q <= '0;
                        iter_q    <= '0;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    {scratch_q, bin_q} <= {scratch_adj, bin_q} << 1;
                    iter_q             <= iter_q + 4'd1;
                    if (iter_q == 4'(CONV_ITERS - 1)) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    bcd_q   <= scratch_q;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/score_display.sv
// score_display: saturates the game score, converts it to BCD and drives a
// 4-digit multiplexed common-anode display; lives shown on decimal points.
// Optional build macro SCORE_DISPLAY_BLINK_EN: blank the display periodically
// when lives == 0.
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 17,
    parameter int unsigned BLINK_BITS   = 25
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [15:0] timealive,
    input  logic [1:0]  lives,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic [13:0]             sat;
    logic [13:0]             last_val_q;
    logic                    conv_start;
    logic                    conv_busy;
    logic                    conv_done_unused;
    logic [15:0]             disp_bcd;
    logic [REFRESH_BITS-1:0] refresh_cnt_q;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic                    dark;
    logic [3:0]              an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;

    assign sat = (timealive > 16'(SAT_MAX)) ? 14'(SAT_MAX) : timealive[13:0];

    // Changes arriving while busy are not lost: last_val lags, so the next
    // idle compare picks up whatever value is current then.
    assign conv_start = !conv_busy && (sat != last_val_q);

    // Remember the value handed to the converter.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            last_val_q <= '0;
        end else if (conv_start) begin
            last_val_q <= sat;
        end
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .clr_n (clr_n),
        .start (conv_start),
        .bin   (sat),
        .busy  (conv_busy),
        .done  (conv_done_unused),
        .bcd   (disp_bcd)
    );

    // Free-running digit refresh counter.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            refresh_cnt_q <= '0;
        end else begin
            refresh_cnt_q <= refresh_cnt_q + REFRESH_BITS'(1);
        end
    end

    assign sel   = refresh_cnt_q[REFRESH_BITS-1 -: 2];
    assign digit = disp_bcd[4*sel +: 4];

`ifdef SCORE_DISPLAY_BLINK_EN
    logic [BLINK_BITS-1:0] blink_cnt_q;

    // Free-running blink timebase for the game-over display.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_BITS'(1);
        end
    end

    assign dark = (lives == 2'd0) && blink_cnt_q[BLINK_BITS-1];
`else
    logic [31:0] blink_bits_unused;
    assign blink_bits_unused = BLINK_BITS;
    assign dark              = 1'b0;
`endif

    // Registered anode/segment/dp drive, one cycle behind sel.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= dark ? 4'b1111 : ~(4'b0001 << sel);
            seg_q <= seg_decode(digit);
            dp_q  <= !(sel < lives);
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: scoreboard bench for score_display. Conversions are pushed
// as expected (bcd, completion cycle) pairs and popped on the converter's done
// pulse; a display monitor checks digit rotation, dwell, segments and dp.
module tb_score_display;

    localparam int RB    = 4;
    localparam int BB    = 5;
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [15:0] timealive = 16'd0;
    logic [1:0]  lives = 2'd3;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    score_display #(
        .REFRESH_BITS (RB),
        .BLINK_BITS   (BB)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .timealive (timealive),
        .lives     (lives),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bcd;
        int          at;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] exp_disp = 16'h0000;
    bit          chk_disp = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [6:0] seg_of(logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Scoreboard monitor: one expected entry per completed conversion.
    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (clr_n && dut.u_conv.done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got bcd %h, required no conversion", dut.disp_bcd);
            end else begin
                e = sb_q.pop_front();
                check("conv_bcd", 32'(dut.disp_bcd), 32'(e.bcd));
                check("conv_latency", cyc, e.at);
            end
        end
    end

    // Display monitor state.
    logic [3:0] prev_an;
    bit         have_prev = 1'b0;
    bit         dwell_ok = 1'b0;
    int         dwell = 0;
    int         idx;

    always @(negedge clk) begin : disp_mon
        if (clr_n && chk_disp) begin
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            check("an_onehot", 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
                check("seg_digit", 32'(seg), 32'(seg_of(exp_disp[4*idx +: 4])));
                check("dp_lives", 32'(dp), 32'(!(idx < int'(lives))));
            end
            if (have_prev && an != prev_an) begin
                check("an_rotate", 32'(an), 32'({prev_an[2:0], prev_an[3]}));
                if (dwell_ok) check("an_dwell", dwell, DWELL);
                dwell_ok = 1'b1;
                dwell    = 1;
            end else if (!have_prev) begin
                dwell = 1;
            end else begin
                dwell++;
            end
            prev_an   = an;
            have_prev = 1'b1;
        end else begin
            have_prev = 1'b0;
            dwell_ok  = 1'b0;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a new score; optionally expect a conversion completing lat cycles later.
    task automatic apply(logic [15:0] v, logic [15:0] bcd, int lat, bit push);
        exp_t e;
        timealive = v;
        if (push) begin
            e.bcd = bcd;
            e.at  = cyc + lat;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL conv_timeout: got %0d pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic show(logic [15:0] d, int n);
        exp_disp = d;
        tick(2);
        chk_disp = 1'b1;
        tick(n);
        chk_disp = 1'b0;
    endtask

    initial begin : stim
        int dark_cnt;
        clr_n     = 1'b0;
        timealive = 16'd0;
        lives     = 2'd3;
        #12;
        check("rst_an", 32'(an), 32'hf);
        check("rst_seg", 32'(seg), 32'h7f);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_bcd", 32'(dut.disp_bcd), 32'h0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        show(16'h0000, 40);

        apply(16'd1234, 16'h1234, 16, 1'b1);
        wait_empty();
        show(16'h1234, 40);

        apply(16'd65535, 16'h9999, 16, 1'b1);
        wait_empty();
        apply(16'd10000, 16'h0000, 0, 1'b0);
        tick(30);
        show(16'h9999, 20);

        // 42 arrives mid-SHIFT: 1234 done at +16, then 42 at +32 from 1234's start.
        apply(16'd1234, 16'h1234, 16, 1'b1);
        tick(5);
        apply(16'd42, 16'h0042, 27, 1'b1);
        wait_empty();
        show(16'h0042, 40);

        // Reset in the middle of SHIFT.
        apply(16'd1234, 16'h1234, 16, 1'b1);
        tick(6);
        clr_n = 1'b0;
        #1;
        sb_q.delete();
        check("midrst_an", 32'(an), 32'hf);
        check("midrst_seg", 32'(seg), 32'h7f);
        check("midrst_dp", 32'(dp), 32'd1);
        check("midrst_bcd", 32'(dut.disp_bcd), 32'h0);
        tick(2);
        clr_n = 1'b1;
        apply(16'd1234, 16'h1234, 16, 1'b1);
        wait_empty();
        show(16'h1234, 40);

        lives = 2'd1;
        tick(2);
        show(16'h1234, 40);

        lives = 2'd0;
        tick(2);
        dark_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            if (an == 4'b1111) dark_cnt++;
        end
`ifdef SCORE_DISPLAY_BLINK_EN
        check("blink_dark", dark_cnt, 32);
`else
        check("no_blink_dark", dark_cnt, 0);
        show(16'h1234, 40);
`endif

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
